elbeth_memory_dp: RTL and testbench

Parametrised dual-port word memory serving the elbeth core. Port A is the instruction port and port B is the data port. Each port has a request/ready handshake, a programmable number of wait states, byte write strobes, and an error response. The error response drives the core's imem_error/dmem_error inputs. The block replaces the fixed single-latency memory and lets core stall handling be exercised under variable latency.

---
 rtl/elbeth_memory_dp_pkg.sv | 29 ++
 rtl/elbeth_memory_dp_port_ctrl.sv | 76 +++++++
 rtl/elbeth_memory_dp.sv | 106 ++++++++++
 tb/tb_elbeth_memory_dp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_memory_dp_pkg.sv
// Shared definitions for the elbeth dual-port memory.
// Holds parameter defaults, the wait-state counter width, the port
// controller state encoding and the strobe-width helper.
package elbeth_memory_dp_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 256;
  localparam int LATENCY_A_DEF  = 0;
  localparam int LATENCY_B_DEF  = 1;
  localparam int PORTA_RO_DEF   = 1;

  // Wait states are limited to 0..15.
  localparam int CNT_W = 4;

  // IDLE: no request held.
  // WAIT: request held, counting down wait states.
  // DONE: request held, access is performed at the coming edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } port_state_t;

  function automatic int strb_w(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/elbeth_memory_dp_port_ctrl.sv
// Per-port request controller: captures a request, counts down the
// configured wait states and raises 'fire' for the single cycle in which
// the memory access must be performed at the next edge.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   en, addr, wdata, rw   incoming request (level-sensitive)
//   fire                  access happens at the coming edge
//   req_addr/wdata/rw     captured request
module elbeth_memory_dp_port_ctrl
  import elbeth_memory_dp_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LATENCY    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] rw,
  output logic                    fire,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [DATA_WIDTH/8-1:0] req_rw
);

  localparam logic [CNT_W-1:0] LAT = LATENCY[CNT_W-1:0];

  port_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = (state_q == ST_DONE);
    // A completing port may take a new request at the same edge.
    accept  = en && (state_q != ST_WAIT);
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1'b1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      cnt_d   = LAT;
      state_d = (LAT == '0) ? ST_DONE : ST_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_rw    <= '0;
    end else if (accept) begin
      req_addr  <= addr;
      req_wdata <= wdata;
      req_rw    <= rw;
    end
  end

endmodule

// File: rtl/elbeth_memory_dp.sv
// Dual-port word memory for the elbeth core. Port A is the instruction
// port, port B the data port. Each port has independent programmable wait
// states, byte write strobes and an error response.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a_en/a_addr/a_wdata/a_rw      port A request (rw = byte strobes, 0 = read)
//   a_rdata/a_ready/a_error       port A response (ready is a 1-cycle pulse)
//   b_*                           same for port B
module elbeth_memory_dp
  import elbeth_memory_dp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LATENCY_A  = LATENCY_A_DEF,
  parameter int LATENCY_B  = LATENCY_B_DEF,
  parameter int PORTA_RO   = PORTA_RO_DEF,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_en,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic [DATA_WIDTH/8-1:0] a_rw,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_ready,
  output logic                    a_error,
  input  logic                    b_en,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  input  logic [DATA_WIDTH/8-1:0] b_rw,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_ready,
  output logic                    b_error
);

  localparam int STRB_W = strb_w(DATA_WIDTH);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  fire_a, fire_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [DATA_WIDTH-1:0] wdata_a, wdata_b;
  logic [STRB_W-1:0]     rw_a, rw_b;

  elbeth_memory_dp_port_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY_A)
  ) u_ctrl_a (
    .clk(clk), .rst(rst), .en(a_en), .addr(a_addr), .wdata(a_wdata), .rw(a_rw),
    .fire(fire_a), .req_addr(addr_a), .req_wdata(wdata_a), .req_rw(rw_a)
  );

  elbeth_memory_dp_port_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY_B)
  ) u_ctrl_b (
    .clk(clk), .rst(rst), .en(b_en), .addr(b_addr), .wdata(b_wdata), .rw(b_rw),
    .fire(fire_b), .req_addr(addr_b), .req_wdata(wdata_b), .req_rw(rw_b)
  );

  logic              err_a, err_b;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [STRB_W-1:0] wr_a, wr_b;

  always_comb begin
    err_a = ({1'b0, addr_a} >= DEPTH_L) || ((PORTA_RO != 0) && (rw_a != '0));
    err_b = ({1'b0, addr_b} >= DEPTH_L);
    idx_a = addr_a[IDX_W-1:0];
    idx_b = addr_b[IDX_W-1:0];
    wr_a  = (fire_a && !err_a) ? rw_a : '0;
    wr_b  = (fire_b && !err_b) ? rw_b : '0;
  end

  // Port B is written after port A so it wins any byte both ports strobe
  // at the same address; A's other bytes still land.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_a[i]) mem[idx_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
        if (wr_b[i]) mem[idx_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
      end
    end
  end

  // Read-first: rdata uses the pre-edge word, so a write returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ready <= 1'b0;
      a_error <= 1'b0;
      a_rdata <= '0;
      b_ready <= 1'b0;
      b_error <= 1'b0;
      b_rdata <= '0;
    end else begin
      a_ready <= fire_a;
      a_error <= fire_a && err_a;
      b_ready <= fire_b;
      b_error <= fire_b && err_b;
      if (fire_a) a_rdata <= err_a ? '0 : mem[idx_a];
      if (fire_b) b_rdata <= err_b ? '0 : mem[idx_b];
    end
  end

endmodule

// File: tb/tb_elbeth_memory_dp.sv
module tb_elbeth_memory_dp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // d1: DEPTH=128, LATENCY_A=0, LATENCY_B=3, port A read-only
  logic        d1_a_en = 0, d1_b_en = 0;
  logic [7:0]  d1_a_addr = 0, d1_b_addr = 0;
  logic [31:0] d1_a_wdata = 0, d1_b_wdata = 0;
  logic [3:0]  d1_a_rw = 0, d1_b_rw = 0;
  logic [31:0] d1_a_rdata, d1_b_rdata;
  logic        d1_a_ready, d1_a_error, d1_b_ready, d1_b_error;

  // d2: DEPTH=256, both ports zero latency, port A writable
  logic        d2_a_en = 0, d2_b_en = 0;
  logic [7:0]  d2_a_addr = 0, d2_b_addr = 0;
  logic [31:0] d2_a_wdata = 0, d2_b_wdata = 0;
  logic [3:0]  d2_a_rw = 0, d2_b_rw = 0;
  logic [31:0] d2_a_rdata, d2_b_rdata;
  logic        d2_a_ready, d2_a_error, d2_b_ready, d2_b_error;

  elbeth_memory_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(128),
    .LATENCY_A(0), .LATENCY_B(3), .PORTA_RO(1), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .a_en(d1_a_en), .a_addr(d1_a_addr), .a_wdata(d1_a_wdata), .a_rw(d1_a_rw),
    .a_rdata(d1_a_rdata), .a_ready(d1_a_ready), .a_error(d1_a_error),
    .b_en(d1_b_en), .b_addr(d1_b_addr), .b_wdata(d1_b_wdata), .b_rw(d1_b_rw),
    .b_rdata(d1_b_rdata), .b_ready(d1_b_ready), .b_error(d1_b_error)
  );

  elbeth_memory_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256),
    .LATENCY_A(0), .LATENCY_B(0), .PORTA_RO(0), .INIT_FILE("")
  ) dut2 (
    .clk(clk), .rst(rst),
    .a_en(d2_a_en), .a_addr(d2_a_addr), .a_wdata(d2_a_wdata), .a_rw(d2_a_rw),
    .a_rdata(d2_a_rdata), .a_ready(d2_a_ready), .a_error(d2_a_error),
    .b_en(d2_b_en), .b_addr(d2_b_addr), .b_wdata(d2_b_wdata), .b_rw(d2_b_rw),
    .b_rdata(d2_b_rdata), .b_ready(d2_b_ready), .b_error(d2_b_error)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One access on d1. lat = number of edges from accept edge to ready.
  task automatic access(input bit port, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] rw, output logic [31:0] rd,
                        output logic er, output int lat);
    @(negedge clk);
    if (port) begin
      d1_b_en = 1; d1_b_addr = addr; d1_b_wdata = wd; d1_b_rw = rw;
    end else begin
      d1_a_en = 1; d1_a_addr = addr; d1_a_wdata = wd; d1_a_rw = rw;
    end
    @(posedge clk); #1;
    d1_a_en = 0; d1_b_en = 0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(port ? d1_b_ready : d1_a_ready) && lat < 40);
    rd = port ? d1_b_rdata : d1_a_rdata;
    er = port ? d1_b_error : d1_a_error;
    @(posedge clk); #1;
    chk("ready_pulse_drop", {31'b0, port ? d1_b_ready : d1_a_ready}, 32'd0);
    chk("error_low_idle",   {31'b0, port ? d1_b_error : d1_a_error}, 32'd0);
    chk("rdata_hold",       port ? d1_b_rdata : d1_a_rdata, rd);
  endtask

  typedef struct {
    bit          port;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [3:0]  rw;
    bit          chk_data;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    vecs[0]  = '{1, 8'h10, 32'hCAFEF00D, 4'hF, 0, 32'h0, 0};
    vecs[1]  = '{1, 8'h20, 32'h11223344, 4'hF, 0, 32'h0, 0};
    vecs[2]  = '{1, 8'h00, 32'h000000A0, 4'hF, 0, 32'h0, 0};
    vecs[3]  = '{1, 8'h01, 32'h000000A1, 4'hF, 0, 32'h0, 0};
    vecs[4]  = '{1, 8'h02, 32'h000000A2, 4'hF, 0, 32'h0, 0};
    vecs[5]  = '{1, 8'h03, 32'h000000A3, 4'hF, 0, 32'h0, 0};
    vecs[6]  = '{1, 8'h04, 32'h44444444, 4'hF, 0, 32'h0, 0};
    vecs[7]  = '{1, 8'h20, 32'hAABBCCDD, 4'h5, 1, 32'h11223344, 0};
    vecs[8]  = '{1, 8'h20, 32'h0,        4'h0, 1, 32'h11BB33DD, 0};
    vecs[9]  = '{1, 8'hFF, 32'h0,        4'h0, 1, 32'h0, 1};
    vecs[10] = '{1, 8'h80, 32'h0,        4'h0, 1, 32'h0, 1};
    vecs[11] = '{0, 8'h10, 32'h12345678, 4'hF, 1, 32'h0, 1};
    vecs[12] = '{0, 8'h10, 32'h0,        4'h0, 1, 32'hCAFEF00D, 0};
    vecs[13] = '{0, 8'h04, 32'h0,        4'h0, 1, 32'h44444444, 0};
    vecs[14] = '{1, 8'h7F, 32'h5A5A5A5A, 4'hF, 0, 32'h0, 0};
    vecs[15] = '{1, 8'h7F, 32'h0,        4'h0, 1, 32'h5A5A5A5A, 0};
    vecs[16] = '{0, 8'h03, 32'h0,        4'h0, 1, 32'h000000A3, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_ready", {31'b0, d1_a_ready}, 32'd0);
    chk("reset_b_ready", {31'b0, d1_b_ready}, 32'd0);
    chk("reset_a_error", {31'b0, d1_a_error}, 32'd0);
    chk("reset_b_rdata", d1_b_rdata, 32'd0);
    chk("reset_a_rdata", d1_a_rdata, 32'd0);
    rst = 0;

    for (int i = 0; i < 17; i++) begin
      access(vecs[i].port, vecs[i].addr, vecs[i].wd, vecs[i].rw, rd, er, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].port ? 32'd4 : 32'd1);
      chk($sformatf("vec%0d_error", i), {31'b0, er}, {31'b0, vecs[i].exp_er});
      if (vecs[i].chk_data) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Both ports accepted at the same edge: A answers after 1 edge, B after 4.
    @(negedge clk);
    d1_a_en = 1; d1_a_addr = 8'h04; d1_a_rw = 0;
    d1_b_en = 1; d1_b_addr = 8'h10; d1_b_rw = 0;
    @(posedge clk); #1;
    d1_a_en = 0; d1_b_en = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_a_ready_c%0d", c), {31'b0, d1_a_ready}, {31'b0, c == 1});
      chk($sformatf("lat_b_ready_c%0d", c), {31'b0, d1_b_ready}, {31'b0, c == 4});
      if (c == 1) chk("lat_a_rdata", d1_a_rdata, 32'h44444444);
      if (c == 4) chk("lat_b_rdata", d1_b_rdata, 32'hCAFEF00D);
    end

    // Back-to-back reads on A with en held high.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d1_a_en = 1; d1_a_addr = 8'(i); d1_a_rw = 0;
      @(posedge clk); #1;
      if (i > 0) begin
        chk($sformatf("b2b_ready%0d", i - 1), {31'b0, d1_a_ready}, 32'd1);
        chk($sformatf("b2b_rdata%0d", i - 1), d1_a_rdata, 32'hA0 + 32'(i - 1));
      end
    end
    @(negedge clk);
    d1_a_en = 0;
    @(posedge clk); #1;
    chk("b2b_ready3", {31'b0, d1_a_ready}, 32'd1);
    chk("b2b_rdata3", d1_a_rdata, 32'hA3);
    @(posedge clk); #1;
    chk("b2b_idle", {31'b0, d1_a_ready}, 32'd0);

    // A request presented while B is busy must be dropped.
    @(negedge clk);
    d1_b_en = 1; d1_b_addr = 8'h00; d1_b_rw = 0;
    @(posedge clk); #1;
    d1_b_addr = 8'h01;
    @(posedge clk); #1;
    d1_b_en = 0;
    for (int c = 2; c <= 9; c++) begin
      @(posedge clk); #1;
      chk($sformatf("busy_b_ready_c%0d", c), {31'b0, d1_b_ready}, {31'b0, c == 4});
      if (c == 4) chk("busy_b_rdata", d1_b_rdata, 32'hA0);
    end

    // Write collision on d2: B wins bytes 0..1, A supplies bytes 2..3.
    @(negedge clk);
    d2_a_en = 1; d2_a_addr = 8'h08; d2_a_wdata = 32'h11111111; d2_a_rw = 4'hF;
    d2_b_en = 1; d2_b_addr = 8'h08; d2_b_wdata = 32'h22222222; d2_b_rw = 4'h3;
    @(posedge clk); #1;
    d2_a_en = 0; d2_b_en = 0;
    @(posedge clk); #1;
    chk("coll_a_ready", {31'b0, d2_a_ready}, 32'd1);
    chk("coll_b_ready", {31'b0, d2_b_ready}, 32'd1);
    chk("coll_a_error", {31'b0, d2_a_error}, 32'd0);
    // A reads while B writes the same word: both see the merged old word.
    @(negedge clk);
    d2_a_en = 1; d2_a_rw = 4'h0;
    d2_b_en = 1; d2_b_wdata = 32'h33333333; d2_b_rw = 4'hF;
    @(posedge clk); #1;
    d2_a_en = 0; d2_b_en = 0;
    @(posedge clk); #1;
    chk("coll_merge_a", d2_a_rdata, 32'h11112222);
    chk("coll_merge_b", d2_b_rdata, 32'h11112222);
    @(negedge clk);
    d2_a_en = 1; d2_a_rw = 4'h0;
    @(posedge clk); #1;
    d2_a_en = 0;
    @(posedge clk); #1;
    chk("rw_conflict_new", d2_a_rdata, 32'h33333333);

    // Reset while a B write is pending with two wait states left.
    @(negedge clk);
    d1_b_en = 1; d1_b_addr = 8'h10; d1_b_wdata = 32'h0BADBEEF; d1_b_rw = 4'hF;
    @(posedge clk); #1;
    d1_b_en = 0;
    @(posedge clk); #1;
    rst = 1; d1_b_en = 1; d1_b_rw = 4'hF;
    @(posedge clk); #1;
    rst = 0; d1_b_en = 0; d1_b_rw = 0;
    chk("rst_b_rdata", d1_b_rdata, 32'd0);
    chk("rst_b_error", {31'b0, d1_b_error}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("rst_no_ready_c%0d", c), {31'b0, d1_b_ready}, 32'd0);
      @(posedge clk); #1;
    end
    access(1, 8'h10, 32'h0, 4'h0, rd, er, lat);
    chk("post_rst_latency", lat, 32'd4);
    chk("post_rst_error", {31'b0, er}, 32'd0);
    chk("post_rst_mem_kept", rd, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
